// File: rtl/dmem_access_unit.sv
// dmem_access_unit: single-request load/store initiator for a byte-addressed data memory.
// Revision 1.0 - initial release.
`default_nettype none

module dmem_access_unit #(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_LIMIT  = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wData,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_errCode,
  output logic [31:0] o_rData,
  output logic        o_DMem_dMemWe,
  output logic        o_DMem_sByte,
  output logic [31:0] o_DMem_addr,
  output logic [31:0] o_DMem_wData,
  input  logic [31:0] i_DMem_rData
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_OP    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic [31:0] rdata_q;

  // Request checking on the incoming (not yet latched) request.
  logic        req_legal;
  logic        req_word;
  logic        req_misaligned;
  logic [32:0] req_end;
  logic        req_oor;
  logic [1:0]  req_code;

  always_comb begin
    req_legal      = (i_op == OP_LW) || (i_op == OP_LB) || (i_op == OP_LBU) ||
                     (i_op == OP_SW) || (i_op == OP_SB);
    req_word       = (i_op == OP_LW) || (i_op == OP_SW);
    req_misaligned = req_word && (i_addr[1:0] != 2'b00);
    req_end        = {1'b0, i_addr} + (req_word ? 33'd4 : 33'd1);
    req_oor        = req_end > 33'(ADDR_LIMIT);
    if (!req_legal)          req_code = ERR_OP;
    else if (req_misaligned) req_code = ERR_ALIGN;
    else if (req_oor)        req_code = ERR_RANGE;
    else                     req_code = ERR_NONE;
  end

  logic        is_store;
  logic        is_byte;
  logic [31:0] load_ext;
  logic        capture;

  assign is_store = op_q[2];
  assign is_byte  = |op_q[1:0];

  always_comb begin
    case (op_q)
      OP_LB:   load_ext = {{24{i_DMem_rData[7]}}, i_DMem_rData[7:0]};
      OP_LBU:  load_ext = {24'd0, i_DMem_rData[7:0]};
      default: load_ext = i_DMem_rData;
    endcase
  end

  always_comb begin
    state_nx      = state;
    o_busy        = 1'b1;
    o_done        = 1'b0;
    o_DMem_dMemWe = 1'b0;
    o_DMem_sByte  = 1'b0;
    o_DMem_addr   = 32'd0;
    o_DMem_wData  = 32'd0;
    capture       = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nx = (req_code != ERR_NONE) ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        o_DMem_sByte  = is_byte;
        o_DMem_addr   = addr_q;
        o_DMem_wData  = wdata_q;
        o_DMem_dMemWe = is_store;
        if (is_store) begin
          state_nx = S_DONE;
        end else if (WAIT_CYCLES == 0) begin
          capture  = 1'b1;
          state_nx = S_DONE;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        o_DMem_sByte = is_byte;
        o_DMem_addr  = addr_q;
        o_DMem_wData = wdata_q;
        if (cnt == 4'd1) begin
          capture  = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q       <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      cnt        <= 4'd0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      rdata_q    <= 32'd0;
    end else begin
      if (state == S_IDLE && i_start) begin
        op_q       <= i_op;
        addr_q     <= i_addr;
        // Byte stores only ever present the low byte to the memory.
        wdata_q    <= (i_op == OP_SB) ? {24'd0, i_wData[7:0]} : i_wData;
        err_q      <= (req_code != ERR_NONE);
        err_code_q <= req_code;
      end
      if (state == S_ACCESS && !is_store) begin
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) rdata_q <= load_ext;
    end
  end

  assign o_err     = err_q;
  assign o_errCode = err_code_q;
  assign o_rData   = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed self-checking bench with a byte-array memory model.
`default_nettype none

module tb_dmem_access_unit;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [31:0] rdata;
  logic        mwe, msb;
  logic [31:0] maddr, mwdata, mrdata;

  logic        start1;
  logic [2:0]  op1;
  logic [31:0] addr1;
  logic        busy1, done1, err1;
  logic [1:0]  err_code1;
  logic [31:0] rdata1;
  logic        mwe1, msb1;
  logic [31:0] maddr1, mwdata1, mrdata1;

  logic [7:0]  mem [0:255];

  int checks = 0;
  int errors = 0;

  dmem_access_unit #(.WAIT_CYCLES(0), .ADDR_LIMIT(256)) dut (
    .clk(clk), .rstn(rstn), .i_start(start), .i_op(op), .i_addr(addr), .i_wData(wdata),
    .o_busy(busy), .o_done(done), .o_err(err), .o_errCode(err_code), .o_rData(rdata),
    .o_DMem_dMemWe(mwe), .o_DMem_sByte(msb), .o_DMem_addr(maddr), .o_DMem_wData(mwdata),
    .i_DMem_rData(mrdata)
  );

  dmem_access_unit #(.WAIT_CYCLES(3), .ADDR_LIMIT(256)) dut_wait (
    .clk(clk), .rstn(rstn), .i_start(start1), .i_op(op1), .i_addr(addr1), .i_wData(32'hCAFE_F00D),
    .o_busy(busy1), .o_done(done1), .o_err(err1), .o_errCode(err_code1), .o_rData(rdata1),
    .o_DMem_dMemWe(mwe1), .o_DMem_sByte(msb1), .o_DMem_addr(maddr1), .o_DMem_wData(mwdata1),
    .i_DMem_rData(mrdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian memory, combinational read; byte reads return a zero-padded byte.
  always_comb begin
    logic [7:0] a;
    a = maddr[7:0];
    if (msb) mrdata = {24'd0, mem[a]};
    else     mrdata = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  end

  always_comb begin
    logic [7:0] a;
    a = maddr1[7:0];
    if (msb1) mrdata1 = {24'd0, mem[a]};
    else      mrdata1 = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  end

  always @(posedge clk) begin
    if (mwe) begin
      if (msb) begin
        mem[maddr[7:0]] <= mwdata[7:0];
      end else begin
        mem[maddr[7:0]]        <= mwdata[7:0];
        mem[maddr[7:0] + 8'd1] <= mwdata[15:8];
        mem[maddr[7:0] + 8'd2] <= mwdata[23:16];
        mem[maddr[7:0] + 8'd3] <= mwdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request; lat counts cycles after the start edge until o_done is seen.
  task automatic run_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         input bit poke, output int lat, output int wes, output logic sb);
    @(negedge clk);
    start = 1'b1; op = o; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
    lat = 1; wes = 0; sb = 1'b0;
    while (!done && lat < 50) begin
      if (mwe) begin
        wes++;
        sb = msb;
      end
      @(negedge clk);
      lat++;
    end
    check("timeout", {31'd0, done}, 32'd1);
    check("done_mem_idle", maddr | mwdata | {30'd0, mwe, msb}, 32'd0);
    if (poke) begin
      start = 1'b1; op = 3'b000; addr = 32'h10;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_ignored", {31'd0, busy}, 32'd0);
    end
  endtask

  int          lat, wes;
  logic        sb;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h78; mem[8'h11] = 8'h56; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;
    start = 0; op = 0; addr = 0; wdata = 0;
    start1 = 0; op1 = 0; addr1 = 0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, err, err_code, mwe, msb}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rstn = 1'b1;

    run_req(3'b000, 32'h10, 32'h0, 1'b0, lat, wes, sb);
    check("lw10_data", rdata, 32'h1234_5678);
    check("lw10_lat", 32'(lat), 32'd2);
    check("lw10_no_we", 32'(wes), 32'd0);
    check("lw10_err", {29'd0, err, err_code}, 32'd0);

    run_req(3'b100, 32'h20, 32'hDEAD_BEEF, 1'b1, lat, wes, sb);
    check("sw20_lat", 32'(lat), 32'd2);
    check("sw20_we_cycles", 32'(wes), 32'd1);
    check("sw20_word", {31'd0, sb}, 32'd0);
    run_req(3'b000, 32'h20, 32'h0, 1'b0, lat, wes, sb);
    check("lw20_data", rdata, 32'hDEAD_BEEF);

    run_req(3'b101, 32'h21, 32'h1234_5680, 1'b0, lat, wes, sb);
    check("sb21_we_cycles", 32'(wes), 32'd1);
    check("sb21_byte", {31'd0, sb}, 32'd1);
    check("sb21_rdata_kept", rdata, 32'hDEAD_BEEF);
    run_req(3'b001, 32'h21, 32'h0, 1'b0, lat, wes, sb);
    check("lb21_data", rdata, 32'hFFFF_FF80);
    run_req(3'b010, 32'h21, 32'h0, 1'b0, lat, wes, sb);
    check("lbu21_data", rdata, 32'h0000_0080);
    check("mem_neighbours", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'hDEAD_80EF);

    run_req(3'b000, 32'h22, 32'h0, 1'b0, lat, wes, sb);
    check("lw22_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});
    check("lw22_lat", 32'(lat), 32'd1);
    check("lw22_no_we", 32'(wes), 32'd0);
    check("lw22_rdata_kept", rdata, 32'h0000_0080);
    @(negedge clk);
    check("err_held", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});

    // Misalignment outranks the range error.
    run_req(3'b100, 32'hFD, 32'h1111_1111, 1'b0, lat, wes, sb);
    check("swFD_code", {30'd0, err_code}, 32'd1);
    run_req(3'b100, 32'h100, 32'h1111_1111, 1'b0, lat, wes, sb);
    check("sw100_code", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd2});
    check("sw100_no_we", 32'(wes), 32'd0);
    run_req(3'b001, 32'h100, 32'h0, 1'b0, lat, wes, sb);
    check("lb100_code", {30'd0, err_code}, 32'd2);
    run_req(3'b011, 32'h22, 32'h0, 1'b0, lat, wes, sb);
    check("op011_code", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd3});
    check("op011_lat", 32'(lat), 32'd1);
    run_req(3'b111, 32'h10, 32'h0, 1'b0, lat, wes, sb);
    check("op111_code", {30'd0, err_code}, 32'd3);
    check("errors_rdata_kept", rdata, 32'h0000_0080);

    run_req(3'b101, 32'hFF, 32'h0000_005A, 1'b0, lat, wes, sb);
    check("sbFF_ok", {29'd0, err, err_code}, 32'd0);
    check("sbFF_we_cycles", 32'(wes), 32'd1);
    run_req(3'b010, 32'hFF, 32'h0, 1'b0, lat, wes, sb);
    check("lbuFF_data", rdata, 32'h0000_005A);
    run_req(3'b000, 32'hFC, 32'h0, 1'b0, lat, wes, sb);
    check("lwFC_ok", {29'd0, err, err_code}, 32'd0);
    check("lwFC_data", rdata, 32'h5A00_0000);

    // Long-latency instance: address must stay put and mid-flight starts are dropped.
    @(negedge clk);
    start1 = 1'b1; op1 = 3'b000; addr1 = 32'h10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start1 = (c == 2);
      if (c == 2) begin
        op1 = 3'b100; addr1 = 32'h40;
      end
      check($sformatf("wait_addr_c%0d", c), maddr1, 32'h10);
      check($sformatf("wait_nodone_c%0d", c), {30'd0, done1, mwe1}, 32'd0);
    end
    start1 = 1'b0;
    @(negedge clk);
    check("wait_done_c5", {31'd0, done1}, 32'd1);
    check("wait_data", rdata1, 32'h1234_5678);
    @(negedge clk);
    check("wait_idle_after", {30'd0, busy1, done1}, 32'd0);

    // Asynchronous reset in the middle of a store's write cycle.
    @(negedge clk);
    start = 1'b1; op = 3'b100; addr = 32'h30; wdata = 32'h1122_3344;
    @(negedge clk);
    start = 1'b0;
    check("rst_pre_we", {31'd0, mwe}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("rst_we_drop", {31'd0, mwe}, 32'd0);
    check("rst_outputs", {busy, done, err, err_code, msb}, 32'd0);
    check("rst_bus", maddr | mwdata | rdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    check("rst_no_done", {30'd0, done, busy}, 32'd0);
    @(negedge clk);
    check("rst_no_done_late", {31'd0, done}, 32'd0);
    check("rst_no_write", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'd0);
    run_req(3'b000, 32'h10, 32'h0, 1'b0, lat, wes, sb);
    check("post_rst_lw", rdata, 32'h1234_5678);
    check("post_rst_lat", 32'(lat), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
